gpr_write_arbiter: RTL and testbench
====================================

// Module: gpr_write_arbiter
// PURPOSE
//   Shares the single GPR-file write port among NUM_REQ writeback sources
//   (e.g. pipeline writeback, load unit, multi-cycle divider).
//   Each source owns a one-entry holding slot; the arbiter grants one full slot
//   per cycle in round-robin order and drives registered write_enable/addr/data
//   straight into the GPR file's write port.
// PARAMETERS
//   NUM_REQ   2   number of requesters (>=2); pointer width = clog2(NUM_REQ)
// PORTS
//   clock          in   1                   single system clock, rising edge
//   reset          in   1                   synchronous, active-high (`ENABLE)
//   flush          in   1                   drop all held writes, block accepts
//   req_valid      in   NUM_REQ             requester i presents a write
//   req_addr       in   NUM_REQ*REGS_ADDR   packed; requester i at [i*W +: W]
//   req_data       in   NUM_REQ*REGS_DATA   packed; requester i at [i*32 +: 32]
//   req_ready      out  NUM_REQ             slot i can take a write this cycle
//   write_enable   out  1                   to GPR file write port
//   write_addr     out  `REGS_ADDR_BUS      to GPR file write port
//   write_data     out  `REGS_DATA_BUS      to GPR file write port
//   busy           out  1                   OR of all slot_full bits
// BEHAVIOUR
//   - Reset (sync): slot_full=0, write_enable=`DISABLE, write_addr=0,
//     write_data=0, rr_ptr=NUM_REQ-1, so requester 0 has priority first.
//   - Transfer on requester i: req_valid[i] && req_ready[i] at a clock edge.
//     The slot latches addr/data; slot_full[i]=1 from the next cycle.
//   - Grant: combinational from registered state only (slot_full, rr_ptr, flush).
//     Grant the first full slot searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
//     At most one grant per cycle. On a grant, rr_ptr <= granted index;
//     otherwise rr_ptr holds.
//   - req_ready[i] = !flush && (!slot_full[i] || grant[i]).
//     No combinational path from req_valid to req_ready. A slot granted this
//     cycle may reload in the same cycle, giving 1 write/cycle for a lone source.
//   - Output register, next cycle after a grant: write_enable=`ENABLE,
//     addr/data = the granted slot. Without a grant: write_enable=`DISABLE and
//     addr/data keep their last values.
//   - Latency: accepted at edge T -> granted in cycle T+1 (if it wins) ->
//     write visible T+2. Worst case T+1+NUM_REQ.
//   - Address 0: granted normally and rr_ptr advances, but write_enable stays
//     `DISABLE. The write is dropped; $zero never gets a write pulse.
//   - Same address from several slots: written in grant order. The last grant wins.
//   - flush=1: no grants, all req_ready=0, every slot_full cleared at the edge,
//     write_enable=`DISABLE next cycle. rr_ptr is unchanged.
//   - reset takes priority over flush. Reset mid-operation discards all held
//     writes; nothing partial reaches the port.
//   - Slot full and not granted: contents are stable. req_valid is ignored
//     because req_ready=0.
// STRUCTURE
//   - Shared package utility.v: `REGS_ADDR_BUS, `REGS_DATA_BUS, `REGS_NUM_LOG,
//     `ENABLE, `DISABLE; add `GPR_WRITERS (default requester count).
//   - Sub-module rr_arbiter: inputs request vector and pointer; output one-hot
//     grant plus encoded index (combinational). Pointer register lives in
//     gpr_write_arbiter.
//   - Top: slot registers, ready logic, output register.
// TESTING
//   1. After reset, req0 sends addr 5 / 32'hDEADBEEF at edge T -> at T+2:
//      write_enable=1, addr=5, data=DEADBEEF. req_ready[0] stays 1 throughout.
//   2. req0 and req1 both valid every cycle, distinct addrs -> grants alternate
//      0,1,0,1. Each write appears exactly once, one write_enable per cycle, none lost.
//   3. req1 sends addr 0 -> req1 accepted, busy pulses, write_enable stays 0.
//      The next simultaneous pair is then granted req0 first.
//   4. Both slots full, flush=1 for one cycle -> req_ready=00, next cycle
//      write_enable=0 and busy=0; neither held write ever appears.
//   5. Reset mid-stream with slots full -> next cycle all outputs 0, busy=0.
//      A new pair issued afterwards is granted req0 first.
//   6. req0 (addr 9, 32'h1) and req1 (addr 9, 32'h2) in the same cycle ->
//      addr 9 written 1 then 2 on consecutive cycles; final value 32'h2.

Source files
------------

// File: rtl/gpr_write_arbiter_pkg.sv
// rtl/gpr_write_arbiter_pkg.sv - shared GPR write-port widths, enables and requester count
// Purpose: common constants for the GPR write arbiter and its round-robin helper.
// Contents: register address/data widths, enable levels, default writer count.
package gpr_write_arbiter_pkg;

    localparam int   REGS_NUM_LOG = 5;              // 32 architectural registers
    localparam int   REGS_ADDR_W  = REGS_NUM_LOG;
    localparam int   REGS_DATA_W  = 32;
    localparam logic ENABLE       = 1'b1;
    localparam logic DISABLE      = 1'b0;
    localparam int   GPR_WRITERS  = 2;              // writeback, load unit

endpackage

// File: rtl/gpr_write_arbiter_rr_arbiter.sv
// rtl/gpr_write_arbiter_rr_arbiter.sv - combinational round-robin grant selector
// Purpose: pick the first asserted request after the pointer, wrapping modulo NUM_REQ.
// Ports:
//   request  in   NUM_REQ  one bit per requester
//   pointer  in   PTR_W    index of the last granted requester
//   grant    out  NUM_REQ  one-hot grant (all zero when nothing requests)
//   index    out  PTR_W    encoded grant index (0 when nothing requests)
//   found    out  1        some request was granted
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   index,
    output logic               found
);

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        // Search pointer+1 .. pointer+NUM_REQ; the last step revisits the
        // pointer itself so a lone requester can win every cycle.
        for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (int'(pointer) + k) % NUM_REQ;
            if (!found && request[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// rtl/gpr_write_arbiter.sv - shares the GPR-file write port among several writeback sources
// Purpose: one holding slot per source, one round-robin grant per cycle, registered write port.
// Ports:
//   clock         in   1                     rising-edge clock
//   reset         in   1                     synchronous, active-high
//   flush         in   1                     drop every held write, refuse new ones
//   req_valid     in   NUM_REQ               source i presents a write
//   req_addr      in   NUM_REQ*REGS_ADDR_W   source i at [i*REGS_ADDR_W +: REGS_ADDR_W]
//   req_data      in   NUM_REQ*REGS_DATA_W   source i at [i*REGS_DATA_W +: REGS_DATA_W]
//   req_ready     out  NUM_REQ               slot i accepts a write this cycle
//   write_enable  out  1                     GPR write strobe
//   write_addr    out  REGS_ADDR_W           GPR write address
//   write_data    out  REGS_DATA_W           GPR write data
//   busy          out  1                     some slot holds a write
module gpr_write_arbiter
    import gpr_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = GPR_WRITERS,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*REGS_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*REGS_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           write_enable,
    output logic [REGS_ADDR_W-1:0]         write_addr,
    output logic [REGS_DATA_W-1:0]         write_data,
    output logic                           busy
);

    logic [NUM_REQ-1:0]     slot_full;
    logic [REGS_ADDR_W-1:0] slot_addr [NUM_REQ];
    logic [REGS_DATA_W-1:0] slot_data [NUM_REQ];
    logic [PTR_W-1:0]       rr_ptr;

    logic [NUM_REQ-1:0]     grant;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_valid;

    // Grants depend only on registered slot state and flush, never on req_valid.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .request (flush ? '0 : slot_full),
        .pointer (rr_ptr),
        .grant   (grant),
        .index   (grant_idx),
        .found   (grant_valid)
    );

    // A slot being drained this cycle can refill at the same edge.
    assign req_ready = {NUM_REQ{!flush}} & (~slot_full | grant);
    assign busy      = |slot_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_full    <= '0;
            rr_ptr       <= PTR_W'(NUM_REQ - 1);
            write_enable <= DISABLE;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush)
                    slot_full[i] <= 1'b0;
                else if (req_valid[i] && req_ready[i])
                    slot_full[i] <= 1'b1;
                else if (grant[i])
                    slot_full[i] <= 1'b0;
            end
            if (grant_valid) begin
                rr_ptr     <= grant_idx;
                write_addr <= slot_addr[grant_idx];
                write_data <= slot_data[grant_idx];
            end
            // $zero is hard-wired: its writes are consumed but never strobed.
            write_enable <= (grant_valid && (slot_addr[grant_idx] != '0)) ? ENABLE : DISABLE;
        end
    end

    // Slot payload is qualified by slot_full, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                slot_addr[i] <= req_addr[i*REGS_ADDR_W +: REGS_ADDR_W];
                slot_data[i] <= req_data[i*REGS_DATA_W +: REGS_DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// tb/tb_gpr_write_arbiter.sv - directed self-checking bench for gpr_write_arbiter
module tb_gpr_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [9:0]  req_addr  = '0;
    logic [63:0] req_data  = '0;
    logic [1:0]  req_ready;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Per-source stimulus lists and the expected write order for run_stream.
    logic [4:0]  sa_addr [4];
    logic [31:0] sa_data [4];
    int          sa_n;
    logic [4:0]  sb_addr [4];
    logic [31:0] sb_data [4];
    int          sb_n;
    logic [4:0]  exp_addr [8];
    logic [31:0] exp_data [8];
    int          exp_n;

    gpr_write_arbiter #(.NUM_REQ(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Enter and leave at 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Each source presents its list in order, advancing on a handshake;
    // writes are expected back to back starting two cycles after the first accept.
    task automatic run_stream(input string tag, input int ncyc);
        int  i0 = 0;
        int  i1 = 0;
        logic h0, h1;
        for (int c = 0; c < ncyc; c++) begin
            req_valid[0]   = (i0 < sa_n);
            req_valid[1]   = (i1 < sb_n);
            req_addr[4:0]  = (i0 < sa_n) ? sa_addr[i0] : 5'd0;
            req_data[31:0] = (i0 < sa_n) ? sa_data[i0] : 32'd0;
            req_addr[9:5]  = (i1 < sb_n) ? sb_addr[i1] : 5'd0;
            req_data[63:32]= (i1 < sb_n) ? sb_data[i1] : 32'd0;
            @(negedge clock);
            h0 = req_valid[0] & req_ready[0];
            h1 = req_valid[1] & req_ready[1];
            check_eq({tag, " we"}, 32'(write_enable), 32'(c >= 2 && c < 2 + exp_n));
            if (c >= 2 && c < 2 + exp_n) begin
                check_eq({tag, " addr"}, 32'(write_addr), 32'(exp_addr[c-2]));
                check_eq({tag, " data"}, write_data, exp_data[c-2]);
            end
            next_cycle();
            if (h0) i0++;
            if (h1) i1++;
        end
        req_valid = '0;
        check_eq({tag, " accepted0"}, i0, sa_n);
        check_eq({tag, " accepted1"}, i1, sb_n);
    endtask

    initial begin
        do_reset();

        // Reset state.
        @(negedge clock);
        check_eq("rst we", 32'(write_enable), 0);
        check_eq("rst addr", 32'(write_addr), 0);
        check_eq("rst data", write_data, 0);
        check_eq("rst busy", 32'(busy), 0);
        check_eq("rst ready", 32'(req_ready), 32'h3);
        next_cycle();

        // 1: single write, latency two edges.
        req_valid = 2'b01; req_addr[4:0] = 5'd5; req_data[31:0] = 32'hDEADBEEF;
        @(negedge clock);
        check_eq("t1 ready T", 32'(req_ready[0]), 1);
        next_cycle();
        req_valid = '0;
        @(negedge clock);
        check_eq("t1 busy T+1", 32'(busy), 1);
        check_eq("t1 we T+1", 32'(write_enable), 0);
        check_eq("t1 ready T+1", 32'(req_ready[0]), 1);
        next_cycle();
        @(negedge clock);
        check_eq("t1 we T+2", 32'(write_enable), 1);
        check_eq("t1 addr", 32'(write_addr), 5);
        check_eq("t1 data", write_data, 32'hDEADBEEF);
        check_eq("t1 busy T+2", 32'(busy), 0);
        check_eq("t1 ready T+2", 32'(req_ready[0]), 1);
        next_cycle();

        // 3: address 0 from req1 (pointer was 0) is consumed silently and moves the pointer.
        req_valid = 2'b10; req_addr[9:5] = 5'd0; req_data[63:32] = 32'h55;
        @(negedge clock);
        check_eq("t3 ready1", 32'(req_ready[1]), 1);
        next_cycle();
        req_valid = '0;
        @(negedge clock);
        check_eq("t3 busy", 32'(busy), 1);
        check_eq("t3 we a", 32'(write_enable), 0);
        next_cycle();
        @(negedge clock);
        check_eq("t3 we b", 32'(write_enable), 0);
        check_eq("t3 busy after", 32'(busy), 0);
        next_cycle();
        sa_n = 1; sa_addr[0] = 5'd11; sa_data[0] = 32'hA;
        sb_n = 1; sb_addr[0] = 5'd12; sb_data[0] = 32'hB;
        exp_n = 2;
        exp_addr[0] = 5'd11; exp_data[0] = 32'hA;
        exp_addr[1] = 5'd12; exp_data[1] = 32'hB;
        run_stream("t3 pair", 5);

        // 2: both sources streaming, grants alternate 0,1,0,1,...
        do_reset();
        sa_n = 3;
        sa_addr[0] = 5'd1; sa_data[0] = 32'd10;
        sa_addr[1] = 5'd3; sa_data[1] = 32'd30;
        sa_addr[2] = 5'd5; sa_data[2] = 32'd50;
        sb_n = 3;
        sb_addr[0] = 5'd2; sb_data[0] = 32'd20;
        sb_addr[1] = 5'd4; sb_data[1] = 32'd40;
        sb_addr[2] = 5'd6; sb_data[2] = 32'd60;
        exp_n = 6;
        exp_addr[0] = 5'd1; exp_data[0] = 32'd10;
        exp_addr[1] = 5'd2; exp_data[1] = 32'd20;
        exp_addr[2] = 5'd3; exp_data[2] = 32'd30;
        exp_addr[3] = 5'd4; exp_data[3] = 32'd40;
        exp_addr[4] = 5'd5; exp_data[4] = 32'd50;
        exp_addr[5] = 5'd6; exp_data[5] = 32'd60;
        run_stream("t2", 10);

        // 6: same address from both, grant order decides the final value.
        do_reset();
        sa_n = 1; sa_addr[0] = 5'd9; sa_data[0] = 32'h1;
        sb_n = 1; sb_addr[0] = 5'd9; sb_data[0] = 32'h2;
        exp_n = 2;
        exp_addr[0] = 5'd9; exp_data[0] = 32'h1;
        exp_addr[1] = 5'd9; exp_data[1] = 32'h2;
        run_stream("t6", 5);

        // 4: flush with both slots full drops both writes.
        req_valid = 2'b11;
        req_addr  = {5'd17, 5'd16};
        req_data  = {32'h17, 32'h16};
        next_cycle();
        req_valid = '0;
        flush = 1'b1;
        @(negedge clock);
        check_eq("t4 busy pre", 32'(busy), 1);
        check_eq("t4 ready", 32'(req_ready), 0);
        next_cycle();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check_eq("t4 we", 32'(write_enable), 0);
            check_eq("t4 busy", 32'(busy), 0);
            next_cycle();
        end
        check_eq("t4 addr held", 32'(write_addr), 9);
        check_eq("t4 data held", write_data, 32'h2);

        // 5: reset with both slots full clears everything.
        req_valid = 2'b11;
        req_addr  = {5'd21, 5'd20};
        req_data  = {32'h21, 32'h20};
        next_cycle();
        req_valid = '0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check_eq("t5 we", 32'(write_enable), 0);
        check_eq("t5 addr", 32'(write_addr), 0);
        check_eq("t5 data", write_data, 0);
        check_eq("t5 busy", 32'(busy), 0);
        next_cycle();
        sa_n = 1; sa_addr[0] = 5'd13; sa_data[0] = 32'hC;
        sb_n = 1; sb_addr[0] = 5'd14; sb_data[0] = 32'hD;
        exp_n = 2;
        exp_addr[0] = 5'd13; exp_data[0] = 32'hC;
        exp_addr[1] = 5'd14; exp_data[1] = 32'hD;
        run_stream("t5 pair", 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
